scope_combiner_rr: RTL and testbench
====================================

Name: scope_combiner_rr

Overview:
Parametrised N-channel AXI-stream combiner for the scope datapath. It merges N_CHANNELS narrow sample streams into one wide output stream. Each input has its own buffer FIFO with true backpressure, so no sample is overwritten. Arbitration between channels is selectable (round-robin or fixed priority). The output carries the originating channel index on user and can generate tlast at a fixed frame length. It sits between the per-channel acquisition front-ends and the scope DMA/packetiser.

Parameters:
INPUT_DATA_WIDTH, 16, width of input sample data
OUTPUT_DATA_WIDTH, 32, width of output data word
DEST_WIDTH, 8, width of dest field on inputs and output
N_CHANNELS, 6, number of input streams (2..16)
FIFO_DEPTH, 4, per-channel buffer depth, power of two, at least 2
ARBITRATION, "ROUND_ROBIN", "ROUND_ROBIN" or "FIXED" (lowest index wins)
MSB_DEST_SUPPORT, "TRUE", "TRUE" packs dest into the output data MSBs
FRAME_LENGTH, 0, output transfers per tlast; 0 means tlast is never asserted

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
stream_in[N_CHANNELS]  axi_stream.slave  data INPUT_DATA_WIDTH, dest DEST_WIDTH  input sample streams
stream_out  axi_stream.master  data OUTPUT_DATA_WIDTH, dest DEST_WIDTH, user 8  combined output

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset state:
  - All FIFOs are empty.
  - stream_out.valid, data, dest, user and tlast are 0.
  - The round-robin pointer holds N_CHANNELS-1, so channel 0 is granted first.
  - The frame counter is 0.
  - stream_in[i].ready is 0 while reset is high.
- Input side:
  - stream_in[i].ready = !full_i && !reset.
  - A word (data, dest) is pushed when valid && ready.
  - There is no bypass: a full FIFO keeps ready low even in a cycle where it is popped.
  - A push and a pop on the same non-empty FIFO in the same cycle leaves the occupancy unchanged.
- Output register:
  - The register loads when (!stream_out.valid || stream_out.ready) and at least one FIFO is non-empty.
  - The granted FIFO is popped on that same edge.
  - If the register is free and all FIFOs are empty, valid goes to 0.
  - While valid && !ready, data, dest, user and tlast are held stable.
- Arbitration:
  - FIXED: the lowest-index non-empty channel wins.
  - ROUND_ROBIN: search starts at pointer+1 (mod N_CHANNELS) and takes the first non-empty channel.
  - The pointer updates to the granted index only on a load.
- Latency: if a handshake occurs in cycle c with all FIFOs empty and the output idle, stream_out.valid is high in cycle c+2. Sustained throughput is 1 word per cycle.
- Data packing:
  - MSB_DEST_SUPPORT="TRUE": data = {dest, sign-extension of sample, sample}. Requires OUTPUT_DATA_WIDTH >= INPUT_DATA_WIDTH+DEST_WIDTH; if equal, there is no extension field.
  - MSB_DEST_SUPPORT="FALSE": data is the sample zero-extended.
  - stream_out.dest = captured dest.
  - stream_out.user = granted channel index, zero-extended to 8 bits.
- Frame counter:
  - Counts output handshakes (valid && ready).
  - tlast is 1 on the word that is the FRAME_LENGTH-th of its frame. The counter wraps to 0 after that handshake.
- Reset mid-operation:
  - Buffered data is discarded and valid drops in the cycle after reset, regardless of ready.
  - No pre-reset word appears on the output after reset is released.
- Elaboration: an illegal parameter combination (packing width too small, FIFO_DEPTH not a power of two) causes an elaboration error.

Test Plan:
1. Defaults. Channel 2 sends data 0x1234 with dest 0x05 once; output ready=1 -> in cycle c+2, valid=1, data=0x05001234, dest=0x05, user=2, tlast=0; valid=0 on the following cycle.
2. Defaults. Channel 0 sends data 0x8001 with dest 0x03 -> data=0x03FF8001. With MSB_DEST_SUPPORT="FALSE" -> data=0x00008001.
3. All 6 channels continuously valid, output ready=1:
   - ROUND_ROBIN: user sequence 0,1,2,3,4,5,0,... with every channel's ready toggling fairly.
   - FIXED: user=0 on every word and channels 1..5 stall with ready=0 once their FIFOs fill.
4. Channel 0 streams 1,2,3,...; output ready=0 for 12 cycles -> exactly 5 words accepted (4 in FIFO, 1 in output register), then stream_in[0].ready=0. Output data stays 1 throughout. On release, the output is 1..5 in order with no loss.
5. FRAME_LENGTH=4, 10 words sent with random output-ready stalls -> tlast=1 only on transfers 4 and 8; tlast held stable during stalls.
6. FIFOs partially filled and output stalled; assert reset for 1 cycle -> valid=0 and all readies 0 during reset. After release, valid stays 0 until new input arrives; the first output equals the first post-reset input.

Source files
------------

// File: rtl/scope_combiner_rr_if.sv
// scope_combiner_rr_if: AXI-stream bundle used for the combiner inputs and output
interface axi_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
    logic                  tlast;
    modport master (output valid, data, dest, user, tlast, input ready);
    modport slave (input valid, data, dest, user, tlast, output ready);
endinterface

// File: rtl/scope_combiner_rr.sv
// scope_combiner_rr: merges N buffered sample streams into one wide stream with selectable arbitration
module scope_combiner_rr #(
    parameter int    INPUT_DATA_WIDTH  = 16,
    parameter int    OUTPUT_DATA_WIDTH = 32,
    parameter int    DEST_WIDTH        = 8,
    parameter int    N_CHANNELS        = 6,
    parameter int    FIFO_DEPTH        = 4,
    parameter string ARBITRATION       = "ROUND_ROBIN",
    parameter string MSB_DEST_SUPPORT  = "TRUE",
    parameter int    FRAME_LENGTH      = 0
) (
    input  logic      clock,
    input  logic      reset,
    axi_stream.slave  stream_in [N_CHANNELS],
    axi_stream.master stream_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(N_CHANNELS);
    localparam int WW = DEST_WIDTH + INPUT_DATA_WIDTH;
    localparam int SW = OUTPUT_DATA_WIDTH - DEST_WIDTH;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (N_CHANNELS < 2 || N_CHANNELS > 16) begin : g_bad_channels
        $error("N_CHANNELS must be in 2..16");
    end
    if (MSB_DEST_SUPPORT == "TRUE" && SW < INPUT_DATA_WIDTH) begin : g_bad_msb_width
        $error("OUTPUT_DATA_WIDTH too small for dest + sample packing");
    end
    if (MSB_DEST_SUPPORT != "TRUE" && OUTPUT_DATA_WIDTH < INPUT_DATA_WIDTH) begin : g_bad_width
        $error("OUTPUT_DATA_WIDTH smaller than INPUT_DATA_WIDTH");
    end

    logic [N_CHANNELS-1:0]        in_valid, in_ready, full, empty, push, pop;
    logic [WW-1:0]                in_word [N_CHANNELS];
    logic [WW-1:0]                mem [N_CHANNELS][FIFO_DEPTH];
    logic [AW:0]                  wr_ptr [N_CHANNELS];
    logic [AW:0]                  rd_ptr [N_CHANNELS];
    logic [CW-1:0]                ptr, grant, idx;
    logic                         found, load;
    logic [WW-1:0]                head;
    logic [OUTPUT_DATA_WIDTH-1:0] word_out;
    logic [31:0]                  frame, frame_after;
    logic                         out_valid, out_last;
    logic [OUTPUT_DATA_WIDTH-1:0] out_data;
    logic [DEST_WIDTH-1:0]        out_dest;
    logic [7:0]                   out_user;

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_ch
        assign in_valid[g]        = stream_in[g].valid;
        assign in_word[g]         = {stream_in[g].dest, stream_in[g].data};
        assign stream_in[g].ready = in_ready[g];
        assign empty[g]           = wr_ptr[g] == rd_ptr[g];
        assign full[g]            = wr_ptr[g] == (rd_ptr[g] ^ (AW+1)'(FIFO_DEPTH));
        assign in_ready[g]        = !full[g] && !reset;
        assign push[g]            = in_valid[g] && in_ready[g];
        assign pop[g]             = load && grant == CW'(g);
    end

    // Pick the first non-empty channel, from index 0 (fixed) or after the last grant (round-robin)
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_CHANNELS; k++) begin
            idx = (ARBITRATION == "FIXED") ? CW'(k) : CW'((int'(ptr) + 1 + k) % N_CHANNELS);
            if (!found && !empty[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    assign load = (!out_valid || stream_out.ready) && found;
    assign head = mem[grant][rd_ptr[grant][AW-1:0]];

    if (MSB_DEST_SUPPORT == "TRUE") begin : g_msb
        assign word_out = {head[WW-1:INPUT_DATA_WIDTH], SW'($signed(head[INPUT_DATA_WIDTH-1:0]))};
    end else begin : g_zext
        assign word_out = OUTPUT_DATA_WIDTH'(head[INPUT_DATA_WIDTH-1:0]);
    end

    assign frame_after = (out_valid && stream_out.ready) ? (out_last ? '0 : frame + 32'd1) : frame;

    // Per-channel FIFO storage and pointers; a full FIFO never accepts, even while being popped
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= in_word[i];
            wr_ptr[i] <= reset ? '0 : wr_ptr[i] + (AW+1)'(push[i]);
            rd_ptr[i] <= reset ? '0 : rd_ptr[i] + (AW+1)'(pop[i]);
        end
    end

    // Output register, round-robin pointer and frame position tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_dest  <= '0;
            out_user  <= '0;
            out_last  <= 1'b0;
            ptr       <= CW'(N_CHANNELS - 1);
            frame     <= '0;
        end else begin
            frame <= frame_after;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= word_out;
                out_dest  <= head[WW-1:INPUT_DATA_WIDTH];
                out_user  <= 8'(grant);
                out_last  <= FRAME_LENGTH != 0 && frame_after == 32'(FRAME_LENGTH - 1);
                ptr       <= grant;
            end else if (stream_out.ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign stream_out.valid = out_valid;
    assign stream_out.data  = out_data;
    assign stream_out.dest  = out_dest;
    assign stream_out.user  = out_user;
    assign stream_out.tlast = out_last;
endmodule

// File: tb/tb_scope_combiner_rr.sv
// tb_scope_combiner_rr: directed bench for the combiner, default and fixed/zero-extend/framed variants
module tb_scope_combiner_rr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    logic [5:0]  in_valid [2];
    logic [15:0] in_data [2][6];
    logic [7:0]  in_dest [2][6];
    logic        out_ready [2];
    wire  [5:0]  in_ready [2];
    wire         out_valid [2];
    wire  [31:0] out_data [2];
    wire  [7:0]  out_dest [2];
    wire  [7:0]  out_user [2];
    wire         out_last [2];

    always #5 clk = ~clk;

    axi_stream #(.DATA_WIDTH(16), .DEST_WIDTH(8), .USER_WIDTH(8)) a_in [6] ();
    axi_stream #(.DATA_WIDTH(16), .DEST_WIDTH(8), .USER_WIDTH(8)) b_in [6] ();
    axi_stream #(.DATA_WIDTH(32), .DEST_WIDTH(8), .USER_WIDTH(8)) a_out ();
    axi_stream #(.DATA_WIDTH(32), .DEST_WIDTH(8), .USER_WIDTH(8)) b_out ();

    for (genvar c = 0; c < 6; c++) begin : g_in
        assign a_in[c].valid  = in_valid[0][c];
        assign a_in[c].data   = in_data[0][c];
        assign a_in[c].dest   = in_dest[0][c];
        assign a_in[c].user   = '0;
        assign a_in[c].tlast  = 1'b0;
        assign in_ready[0][c] = a_in[c].ready;
        assign b_in[c].valid  = in_valid[1][c];
        assign b_in[c].data   = in_data[1][c];
        assign b_in[c].dest   = in_dest[1][c];
        assign b_in[c].user   = '0;
        assign b_in[c].tlast  = 1'b0;
        assign in_ready[1][c] = b_in[c].ready;
    end

    assign a_out.ready  = out_ready[0];
    assign out_valid[0] = a_out.valid;
    assign out_data[0]  = a_out.data;
    assign out_dest[0]  = a_out.dest;
    assign out_user[0]  = a_out.user;
    assign out_last[0]  = a_out.tlast;
    assign b_out.ready  = out_ready[1];
    assign out_valid[1] = b_out.valid;
    assign out_data[1]  = b_out.data;
    assign out_dest[1]  = b_out.dest;
    assign out_user[1]  = b_out.user;
    assign out_last[1]  = b_out.tlast;

    scope_combiner_rr dut_a (
        .clock(clk), .reset(rst), .stream_in(a_in), .stream_out(a_out)
    );

    scope_combiner_rr #(
        .ARBITRATION("FIXED"), .MSB_DEST_SUPPORT("FALSE"), .FRAME_LENGTH(4)
    ) dut_b (
        .clock(clk), .reset(rst), .stream_in(b_in), .stream_out(b_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        for (int u = 0; u < 2; u++) begin
            in_valid[u] = '0;
            for (int c = 0; c < 6; c++) begin
                in_data[u][c] = '0;
                in_dest[u][c] = '0;
            end
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        int          acc, n, w;
        int          rdy_cnt [6];
        logic        v, r, t, pv, pr, pt;
        logic [31:0] d, pd;
        logic [15:0] pat;
        idle_inputs();
        out_ready[0] = 1'b1;
        out_ready[1] = 1'b1;
        rst = 1'b1;
        step();
        chk("rst_valid", out_valid[0], 0);
        chk("rst_ready", in_ready[0], 0);
        step();
        rst = 1'b0;
        step();
        chk("idle_ready", in_ready[0], 6'h3f);
        chk("idle_valid", out_valid[0], 0);
        chk("idle_data", out_data[0], 0);
        chk("idle_dest", out_dest[0], 0);
        chk("idle_user", out_user[0], 0);
        chk("idle_last", out_last[0], 0);

        // single word on channel 2, visible two cycles after its handshake
        in_valid[0][2] = 1'b1;
        in_data[0][2]  = 16'h1234;
        in_dest[0][2]  = 8'h05;
        step();
        idle_inputs();
        chk("t1_c1_valid", out_valid[0], 0);
        step();
        chk("t1_valid", out_valid[0], 1);
        chk("t1_data", out_data[0], 32'h05001234);
        chk("t1_dest", out_dest[0], 8'h05);
        chk("t1_user", out_user[0], 2);
        chk("t1_last", out_last[0], 0);
        step();
        chk("t1_after", out_valid[0], 0);

        // negative sample: sign-extended with dest on top, or plain zero-extended
        for (int u = 0; u < 2; u++) begin
            in_valid[u][0] = 1'b1;
            in_data[u][0]  = 16'h8001;
            in_dest[u][0]  = 8'h03;
        end
        step();
        idle_inputs();
        step();
        chk("t2_sext", out_data[0], 32'h03FF8001);
        chk("t2_zext", out_data[1], 32'h00008001);
        chk("t2_zext_valid", out_valid[1], 1);
        chk("t2_zext_dest", out_dest[1], 8'h03);
        step();
        chk("t2_after_a", out_valid[0], 0);
        chk("t2_after_b", out_valid[1], 0);

        // every channel valid: round-robin rotates, fixed priority starves 1..5
        do_reset();
        for (int u = 0; u < 2; u++) begin
            in_valid[u] = 6'h3f;
            for (int c = 0; c < 6; c++) begin
                in_data[u][c] = 16'(c * 256 + 171);
                in_dest[u][c] = 8'(c);
            end
        end
        for (int c = 0; c < 6; c++) rdy_cnt[c] = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k >= 2) begin
                chk("t3_rr_valid", out_valid[0], 1);
                chk("t3_rr_user", out_user[0], (k - 2) % 6);
                chk("t3_rr_data", out_data[0], {8'((k - 2) % 6), 8'h00, 16'(((k - 2) % 6) * 256 + 171)});
                chk("t3_fx_valid", out_valid[1], 1);
                chk("t3_fx_user", out_user[1], 0);
                chk("t3_fx_data", out_data[1], 32'h000000AB);
            end
            if (k >= 4) chk("t3_fx_ready", in_ready[1], 6'h01);
            if (k >= 8 && k <= 19)
                for (int c = 0; c < 6; c++) rdy_cnt[c] += int'(in_ready[0][c]);
        end
        for (int c = 0; c < 6; c++) chk("t3_rr_fair", rdy_cnt[c], 2);

        // output stalled: one word in the register plus a full FIFO, then drained in order
        do_reset();
        out_ready[0] = 1'b0;
        w = 1;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            in_valid[0][0] = 1'b1;
            in_data[0][0]  = 16'(w);
            r = in_ready[0][0];
            step();
            if (r) begin
                w++;
                acc++;
            end
            if (k >= 1) begin
                chk("t4_hold_valid", out_valid[0], 1);
                chk("t4_hold_data", out_data[0], 1);
            end
        end
        chk("t4_accepted", acc, 5);
        chk("t4_ready_low", in_ready[0][0], 0);
        in_valid[0] = '0;
        out_ready[0] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            chk("t4_drain_valid", out_valid[0], 1);
            chk("t4_drain_data", out_data[0], i);
            step();
        end
        chk("t4_drain_end", out_valid[0], 0);

        // framed variant: tlast on every fourth transfer, held during stalls
        do_reset();
        pat = 16'b1011_0010_1101_1001;
        w = 1;
        n = 0;
        pv = 1'b0;
        pr = 1'b1;
        pd = '0;
        pt = 1'b0;
        for (int k = 0; k < 120 && n < 10; k++) begin
            if (pv && !pr) begin
                chk("t5_hold_data", out_data[1], pd);
                chk("t5_hold_last", out_last[1], pt);
            end
            out_ready[1]   = pat[k % 16];
            in_valid[1][0] = w <= 10;
            in_data[1][0]  = 16'(w);
            acc = int'(in_ready[1][0] && w <= 10);
            v = out_valid[1];
            d = out_data[1];
            t = out_last[1];
            r = out_ready[1];
            if (v && r) begin
                n++;
                chk("t5_data", d, n);
                chk("t5_tlast", t, n % 4 == 0);
            end
            pv = v;
            pr = r;
            pd = d;
            pt = t;
            step();
            if (acc != 0) w++;
        end
        chk("t5_count", n, 10);
        out_ready[1] = 1'b1;

        // reset with buffered data and a stalled output discards everything
        do_reset();
        out_ready[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[0]   = 6'b001010;
            in_data[0][1] = 16'(16'h0100 + k);
            in_data[0][3] = 16'(16'h0300 + k);
            step();
        end
        chk("t6_pre_valid", out_valid[0], 1);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("t6_rst_ready_now", in_ready[0], 0);
        step();
        chk("t6_rst_valid", out_valid[0], 0);
        chk("t6_rst_ready", in_ready[0], 0);
        rst = 1'b0;
        out_ready[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t6_idle_valid", out_valid[0], 0);
        end
        chk("t6_idle_ready", in_ready[0], 6'h3f);
        in_valid[0][4] = 1'b1;
        in_data[0][4]  = 16'h00AA;
        in_dest[0][4]  = 8'h07;
        step();
        idle_inputs();
        step();
        chk("t6_new_valid", out_valid[0], 1);
        chk("t6_new_data", out_data[0], 32'h070000AA);
        chk("t6_new_user", out_user[0], 4);
        step();
        chk("t6_new_after", out_valid[0], 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
